// File: rtl/coef_sequencer_if.sv
// Bundle between coef_sequencer and its environment: coefficient stream,
// coefficient-memory port, MAC-side coefficient output and status flags.
interface coef_sequencer_if #(
  parameter int AW = 6,
  parameter int DW = 16
);
  logic          load_start;
  logic          cin_valid;
  logic          cin_ready;
  logic [DW-1:0] cin_data;
  logic          sample_strobe;
  logic [AW-1:0] mem_addr;
  logic          mem_w_en;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          coef_valid;
  logic [AW-1:0] coef_idx;
  logic [DW-1:0] coef_data;
  logic          coef_last;
  logic          loaded;
  logic          busy;
  logic          strobe_drop;

  modport master (
    input  load_start, cin_valid, cin_data, sample_strobe, mem_rdata,
    output cin_ready, mem_addr, mem_w_en, mem_wdata,
    output coef_valid, coef_idx, coef_data, coef_last, loaded, busy, strobe_drop
  );

  modport slave (
    output load_start, cin_valid, cin_data, sample_strobe, mem_rdata,
    input  cin_ready, mem_addr, mem_w_en, mem_wdata,
    input  coef_valid, coef_idx, coef_data, coef_last, loaded, busy, strobe_drop
  );
endinterface

// File: rtl/coef_sequencer.sv
// FIR coefficient memory controller: streams a full reload into the memory, then on each
// sample strobe sweeps all taps out; coef outputs lag mem_addr by the 1-cycle read latency.
module coef_sequencer #(
  parameter int TAPS = 64,
  parameter int AW   = 6,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  coef_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, READY, SWEEP} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          loaded_q, loaded_nxt;
  logic          drop_q, drop_nxt;
  logic          cvld_q;
  logic [AW-1:0] cidx_q;
  logic          wr;
  logic          last_cnt;

  assign last_cnt = (cnt == AW'(TAPS - 1));
  assign wr       = (state == LOAD) && bus.cin_valid;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    loaded_nxt     = loaded_q;
    drop_nxt       = drop_q;
    bus.cin_ready  = 1'b0;
    bus.mem_w_en   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.busy       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_nxt  = LOAD;
          cnt_nxt    = '0;
          loaded_nxt = 1'b0;
          drop_nxt   = 1'b0;
        end
        if (bus.sample_strobe) drop_nxt = 1'b1;
      end

      LOAD: begin
        bus.cin_ready = 1'b1;
        bus.busy      = 1'b1;
        if (wr) begin
          bus.mem_w_en  = 1'b1;
          bus.mem_addr  = cnt;
          bus.mem_wdata = bus.cin_data;
          if (last_cnt) begin
            state_nxt  = READY;
            loaded_nxt = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        // A restart overrides even a completing final beat.
        if (bus.load_start) begin
          state_nxt  = LOAD;
          cnt_nxt    = '0;
          loaded_nxt = 1'b0;
          drop_nxt   = 1'b0;
        end
        if (bus.sample_strobe) drop_nxt = 1'b1;
      end

      READY: begin
        if (bus.load_start) begin
          state_nxt  = LOAD;
          cnt_nxt    = '0;
          loaded_nxt = 1'b0;
          drop_nxt   = bus.sample_strobe;
        end else if (bus.sample_strobe) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end

      SWEEP: begin
        bus.busy     = 1'b1;
        bus.mem_addr = cnt;
        if (last_cnt) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
        if (bus.sample_strobe) drop_nxt = 1'b1;
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      loaded_q <= 1'b0;
      drop_q   <= 1'b0;
      cvld_q   <= 1'b0;
      cidx_q   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      loaded_q <= loaded_nxt;
      drop_q   <= drop_nxt;
      cvld_q   <= (state == SWEEP);
      cidx_q   <= (state == SWEEP) ? bus.mem_addr : '0;
    end
  end

  assign bus.coef_valid  = cvld_q;
  assign bus.coef_idx    = cidx_q;
  assign bus.coef_data   = bus.mem_rdata;
  assign bus.coef_last   = cvld_q && (cidx_q == AW'(TAPS - 1));
  assign bus.loaded      = loaded_q;
  assign bus.strobe_drop = drop_q;

endmodule

// File: tb/tb_coef_sequencer.sv
// Scoreboard bench for coef_sequencer with a behavioural 1-cycle-read coefficient memory.
module tb_coef_sequencer;
  localparam int TAPS = 64;
  localparam int AW   = 6;
  localparam int DW   = 16;

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t wr_q[$];
  exp_t rd_q[$];
  logic [DW-1:0] exp_coef [TAPS];
  logic [DW-1:0] mem [TAPS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  coef_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  coef_sequencer #(.TAPS(TAPS), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always @(posedge clk) begin
    if (bus.mem_w_en) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Every memory write and every coefficient beat must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.mem_w_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else begin
          e = wr_q.pop_front();
          check("wr_cyc", cyc, e.cyc);
          check("wr_addr", 32'(bus.mem_addr), 32'(e.a));
          check("wr_data", 32'(bus.mem_wdata), 32'(e.d));
        end
      end
      if (bus.coef_valid) begin
        if (rd_q.size() == 0) check("coef_unexpected", 32'd1, 32'd0);
        else begin
          e = rd_q.pop_front();
          check("coef_cyc", cyc, e.cyc);
          check("coef_idx", 32'(bus.coef_idx), 32'(e.a));
          check("coef_data", 32'(bus.coef_data), 32'(e.d));
          check("coef_last", 32'(bus.coef_last), 32'(e.last));
        end
      end else begin
        check("last_without_valid", 32'(bus.coef_last), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [DW-1:0] base, input bit gaps);
    int i;
    int k;
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    i = 0;
    k = 0;
    while (i < TAPS) begin
      bus.cin_valid = !gaps || (k % 2 == 0);
      if (bus.cin_valid) begin
        bus.cin_data = base + DW'(i);
        exp_coef[i] = base + DW'(i);
        wr_q.push_back('{cyc, AW'(i), base + DW'(i), 1'b0});
        if (i == TAPS - 1) check("loaded_before_last", 32'(bus.loaded), 32'd0);
        i++;
      end
      k++;
      step();
    end
    bus.cin_valid = 1'b0;
    check("loaded_after_last", 32'(bus.loaded), 32'd1);
    check("busy_after_load", 32'(bus.busy), 32'd0);
  endtask

  // Strobe is being driven in the current cycle.
  task automatic expect_sweep();
    for (int k = 0; k < TAPS; k++)
      rd_q.push_back('{cyc + 2 + k, AW'(k), exp_coef[k], k == TAPS - 1});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_coef_valid"}, 32'(bus.coef_valid), 32'd0);
    check({tag, "_coef_idx"}, 32'(bus.coef_idx), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_w_en"}, 32'(bus.mem_w_en), 32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_cin_ready"}, 32'(bus.cin_ready), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_loaded"}, 32'(bus.loaded), 32'd0);
    check({tag, "_strobe_drop"}, 32'(bus.strobe_drop), 32'd0);
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.cin_valid = 1'b0;
    bus.cin_data = '0;
    bus.sample_strobe = 1'b0;
    #3;
    check_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Contiguous load, then one full sweep.
    do_load(16'h1000, 1'b0);
    bus.sample_strobe = 1'b1;
    expect_sweep();
    step();
    bus.sample_strobe = 1'b0;
    check("sweep_busy", 32'(bus.busy), 32'd1);
    repeat (TAPS) step();
    check("sweep_end_busy", 32'(bus.busy), 32'd0);
    check("sweep_end_last", 32'(bus.coef_last), 32'd1);
    step();
    check("sweep_drained", 32'(rd_q.size()), 32'd0);
    check("sweep_no_drop", 32'(bus.strobe_drop), 32'd0);

    // Gapped load, then a strobe landing on the last sweep edge is dropped.
    do_load(16'h2000, 1'b1);
    bus.sample_strobe = 1'b1;
    expect_sweep();
    step();
    bus.sample_strobe = 1'b0;
    repeat (TAPS - 1) step();
    bus.sample_strobe = 1'b1;
    step();
    bus.sample_strobe = 1'b0;
    repeat (70) step();
    check("e64_drop", 32'(bus.strobe_drop), 32'd1);
    check("e64_drained", 32'(rd_q.size()), 32'd0);

    // Reload clears the drop flag; strobes TAPS+1 apart both sweep.
    do_load(16'h3000, 1'b0);
    check("reload_drop_clear", 32'(bus.strobe_drop), 32'd0);
    bus.sample_strobe = 1'b1;
    expect_sweep();
    step();
    bus.sample_strobe = 1'b0;
    repeat (TAPS) step();
    bus.sample_strobe = 1'b1;
    expect_sweep();
    step();
    bus.sample_strobe = 1'b0;
    repeat (70) step();
    check("e65_no_drop", 32'(bus.strobe_drop), 32'd0);
    check("e65_drained", 32'(rd_q.size()), 32'd0);

    // load_start beats a simultaneous strobe in READY.
    bus.load_start = 1'b1;
    bus.sample_strobe = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.sample_strobe = 1'b0;
    check("prio_busy", 32'(bus.busy), 32'd1);
    check("prio_cin_ready", 32'(bus.cin_ready), 32'd1);
    check("prio_loaded", 32'(bus.loaded), 32'd0);
    check("prio_drop", 32'(bus.strobe_drop), 32'd1);
    repeat (70) step();

    // Reset during beat 30 of a load.
    for (int i = 0; i < 30; i++) begin
      bus.cin_valid = 1'b1;
      bus.cin_data = 16'h4000 + DW'(i);
      wr_q.push_back('{cyc, AW'(i), 16'h4000 + DW'(i), 1'b0});
      step();
    end
    bus.cin_data = 16'h401E;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midload_reset");
    bus.cin_valid = 1'b0;
    check("midload_wr_drained", 32'(wr_q.size()), 32'd0);
    wr_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    bus.sample_strobe = 1'b1;
    step();
    bus.sample_strobe = 1'b0;
    check("post_reset_drop", 32'(bus.strobe_drop), 32'd1);
    repeat (70) step();
    check("post_reset_busy", 32'(bus.busy), 32'd0);
    check("post_reset_loaded", 32'(bus.loaded), 32'd0);
    check("final_rd_empty", 32'(rd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
